// File: rtl/cart_pkg.sv
// Constants and helpers shared by the cartridge bank table and the mapper logic.
package cart_pkg;

  localparam logic [15:0] ROML_LADDR  = 16'h8000;
  localparam logic [15:0] BANK8K_SIZE = 16'h2000;

  localparam int CART_BANK_W = 8;
  localparam int CART_PAGE_W = 12;
  localparam int CART_NCH    = 2;

  // Sets every bit at and below the highest set bit of v.
  function automatic logic [15:0] smear16(input logic [15:0] v);
    logic [15:0] s;
    s = v;
    for (int i = 14; i >= 0; i--) begin
      s[i] = s[i] | s[i+1];
    end
    return s;
  endfunction

endpackage

// File: rtl/cart_rr_arb.sv
// Round-robin arbiter: one-hot grant among unmasked requesters, none while stalled.
module cart_rr_arb #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic         stall_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  elig;

  assign elig = req_i & ~mask_i;

  // Search starts at ptr_q; the pointer moves one past the winner.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!stall_i && !found && elig[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = PW'((int'(idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cart_bank_table.sv
// CRT bank-to-SDRAM-page table: filled from chip packet headers, read by
// several mapper channels through a round-robin, two-stage lookup pipeline.
module cart_bank_table
  import cart_pkg::*;
#(
  parameter int BANK_W = CART_BANK_W,
  parameter int PAGE_W = CART_PAGE_W,
  parameter int NCH    = CART_NCH
) (
  input  logic                  clk32,
  input  logic                  reset,
  input  logic                  cart_loading,
  input  logic                  cart_bank_wr,
  input  logic [15:0]           cart_bank_num,
  input  logic [15:0]           cart_bank_laddr,
  input  logic [15:0]           cart_bank_size,
  input  logic [24:0]           cart_bank_raddr,
  output logic [BANK_W:0]       bank_cnt,
  output logic [BANK_W-1:0]     bank_mask,
  output logic                  table_ready,
  output logic                  err_overflow,
  input  logic [NCH-1:0]        lk_req,
  input  logic [NCH*BANK_W-1:0] lk_bank,
  input  logic [NCH-1:0]        lk_hi,
  output logic [NCH-1:0]        lk_ack,
  output logic [NCH*PAGE_W-1:0] lk_page,
  output logic [NCH-1:0]        lk_valid
);

  localparam int DEPTH = 1 << BANK_W;
  localparam logic [BANK_W:0] CNT_MAX = '1;

  logic              loading_q, load_start, load_end;
  logic              bank_ovf, bank_zero, wr_lo, wr_hi;
  logic [BANK_W-1:0] wr_bank;
  logic [PAGE_W-1:0] wr_page, hi_wdata;
  logic [15:0]       wr_smear;
  logic              unused_bits;

  logic [BANK_W:0]   bank_cnt_q, bank_cnt_d;
  logic [BANK_W-1:0] bank_mask_q, bank_mask_d;
  logic              ready_q, ready_d, ovf_q, ovf_d;
  logic [PAGE_W-1:0] base_lo_q, base_lo_d, base_hi_q, base_hi_d;
  logic [DEPTH-1:0]  vlo_q, vlo_d, vhi_q, vhi_d;

  logic [PAGE_W-1:0] lo_mem [DEPTH];
  logic [PAGE_W-1:0] hi_mem [DEPTH];

  assign load_start  = cart_loading & ~loading_q;
  assign load_end    = ~cart_loading & loading_q;
  assign wr_page     = cart_bank_raddr[PAGE_W+12:13];
  assign wr_bank     = cart_bank_num[BANK_W-1:0];
  assign wr_smear    = smear16(cart_bank_num);
  assign bank_ovf    = (cart_bank_num >> BANK_W) != 16'd0;
  assign bank_zero   = (wr_bank == '0);
  assign unused_bits = ^{cart_bank_raddr[12:0], wr_smear};

  // A ROML packet longer than 8K carries its ROMH half in the next SDRAM page.
  assign wr_lo    = cart_bank_wr & ~bank_ovf & (cart_bank_laddr <= ROML_LADDR);
  assign wr_hi    = cart_bank_wr & ~bank_ovf &
                    ((cart_bank_laddr > ROML_LADDR) | (cart_bank_size > BANK8K_SIZE));
  assign hi_wdata = (cart_bank_laddr <= ROML_LADDR) ? wr_page + PAGE_W'(1) : wr_page;

  // Load start clears first, so a packet in the same cycle still lands.
  always_comb begin
    bank_cnt_d  = load_start ? '0 : bank_cnt_q;
    bank_mask_d = load_start ? '0 : bank_mask_q;
    ovf_d       = ovf_q & ~load_start;
    ready_d     = ready_q & ~load_start;
    base_lo_d   = load_start ? '0 : base_lo_q;
    base_hi_d   = load_start ? '0 : base_hi_q;
    vlo_d       = load_start ? '0 : vlo_q;
    vhi_d       = load_start ? '0 : vhi_q;
    if (cart_bank_wr) begin
      if (bank_cnt_d != CNT_MAX) bank_cnt_d = bank_cnt_d + (BANK_W+1)'(1);
      if (bank_ovf) ovf_d = 1'b1;
      else bank_mask_d = bank_mask_d | wr_smear[BANK_W-1:0];
    end
    if (wr_lo) begin
      vlo_d[wr_bank] = 1'b1;
      if (bank_zero) base_lo_d = wr_page;
    end
    if (wr_hi) begin
      vhi_d[wr_bank] = 1'b1;
      if (bank_zero) base_hi_d = hi_wdata;
    end
    if (load_end) ready_d = (bank_cnt_d != '0);
  end

  always_ff @(posedge clk32 or negedge reset) begin
    if (!reset) begin
      loading_q   <= 1'b0;
      bank_cnt_q  <= '0;
      bank_mask_q <= '0;
      ready_q     <= 1'b0;
      ovf_q       <= 1'b0;
      base_lo_q   <= '0;
      base_hi_q   <= '0;
      vlo_q       <= '0;
      vhi_q       <= '0;
    end else begin
      loading_q   <= cart_loading;
      bank_cnt_q  <= bank_cnt_d;
      bank_mask_q <= bank_mask_d;
      ready_q     <= ready_d;
      ovf_q       <= ovf_d;
      base_lo_q   <= base_lo_d;
      base_hi_q   <= base_hi_d;
      vlo_q       <= vlo_d;
      vhi_q       <= vhi_d;
    end
  end

  assign bank_cnt     = bank_cnt_q;
  assign bank_mask    = bank_mask_q;
  assign table_ready  = ready_q;
  assign err_overflow = ovf_q;

  logic [NCH-1:0]    arb_gnt, gnt_q, ack_q;
  logic [BANK_W-1:0] sel_bank, rd_addr_q;
  logic              sel_hi, rd_hi_sel_q, s1_hi_q, s1_vld_q;
  logic [PAGE_W-1:0] s1_fb_q, rd_lo_q, rd_hi_q, res_page;

  // A channel granted last edge is still in flight and sits out this round.
  cart_rr_arb #(.N(NCH)) u_arb (
    .clk     (clk32),
    .rst_n   (reset),
    .req_i   (lk_req),
    .mask_i  (gnt_q),
    .stall_i (cart_bank_wr),
    .gnt_o   (arb_gnt)
  );

  always_comb begin
    sel_bank = '0;
    sel_hi   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (arb_gnt[c]) begin
        sel_bank = lk_bank[c*BANK_W +: BANK_W];
        sel_hi   = lk_hi[c];
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (wr_lo) lo_mem[wr_bank] <= wr_page;
    if (wr_hi) hi_mem[wr_bank] <= hi_wdata;
    if (|gnt_q) begin
      rd_lo_q <= lo_mem[rd_addr_q];
      rd_hi_q <= hi_mem[rd_addr_q];
    end
  end

  // Valid bits are sampled with the RAM read; a load start at that edge forces fallback.
  always_ff @(posedge clk32 or negedge reset) begin
    if (!reset) begin
      gnt_q       <= '0;
      ack_q       <= '0;
      rd_addr_q   <= '0;
      rd_hi_sel_q <= 1'b0;
      s1_hi_q     <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_fb_q     <= '0;
    end else begin
      gnt_q <= arb_gnt;
      ack_q <= gnt_q;
      if (|arb_gnt) begin
        rd_addr_q   <= sel_bank & bank_mask_q;
        rd_hi_sel_q <= sel_hi;
      end
      if (|gnt_q) begin
        s1_hi_q  <= rd_hi_sel_q;
        s1_vld_q <= ~load_start & (rd_hi_sel_q ? vhi_q[rd_addr_q] : vlo_q[rd_addr_q]);
        s1_fb_q  <= load_start ? '0 : (rd_hi_sel_q ? base_hi_q : base_lo_q);
      end
    end
  end

  assign res_page = s1_vld_q ? (s1_hi_q ? rd_hi_q : rd_lo_q) : s1_fb_q;
  assign lk_ack   = ack_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [PAGE_W-1:0] page_q;
    logic              valid_q;

    always_ff @(posedge clk32 or negedge reset) begin
      if (!reset) begin
        page_q  <= '0;
        valid_q <= 1'b0;
      end else if (ack_q[gi]) begin
        page_q  <= res_page;
        valid_q <= s1_vld_q;
      end
    end

    assign lk_page[gi*PAGE_W +: PAGE_W] = ack_q[gi] ? res_page : page_q;
    assign lk_valid[gi]                 = ack_q[gi] ? s1_vld_q : valid_q;
  end

endmodule

// File: tb/tb_cart_bank_table.sv
// Self-checking bench for cart_bank_table against an array-based table model.
module tb_cart_bank_table;

  localparam int BANK_W = 8;
  localparam int PAGE_W = 12;
  localparam int NCH    = 2;
  localparam int DEPTH  = 1 << BANK_W;

  logic clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  logic                  reset, cart_loading, cart_bank_wr;
  logic [15:0]           cart_bank_num, cart_bank_laddr, cart_bank_size;
  logic [24:0]           cart_bank_raddr;
  logic [BANK_W:0]       bank_cnt;
  logic [BANK_W-1:0]     bank_mask;
  logic                  table_ready, err_overflow;
  logic [NCH-1:0]        lk_req, lk_hi, lk_ack, lk_valid;
  logic [NCH*BANK_W-1:0] lk_bank;
  logic [NCH*PAGE_W-1:0] lk_page;

  cart_bank_table #(.BANK_W(BANK_W), .PAGE_W(PAGE_W), .NCH(NCH)) dut (
    .clk32           (clk32),
    .reset           (reset),
    .cart_loading    (cart_loading),
    .cart_bank_wr    (cart_bank_wr),
    .cart_bank_num   (cart_bank_num),
    .cart_bank_laddr (cart_bank_laddr),
    .cart_bank_size  (cart_bank_size),
    .cart_bank_raddr (cart_bank_raddr),
    .bank_cnt        (bank_cnt),
    .bank_mask       (bank_mask),
    .table_ready     (table_ready),
    .err_overflow    (err_overflow),
    .lk_req          (lk_req),
    .lk_bank         (lk_bank),
    .lk_hi           (lk_hi),
    .lk_ack          (lk_ack),
    .lk_page         (lk_page),
    .lk_valid        (lk_valid)
  );

  int tests = 0;
  int fails = 0;

  // Reference model of the table contents and status.
  int m_lo [DEPTH];
  int m_hi [DEPTH];
  bit m_vlo[DEPTH];
  bit m_vhi[DEPTH];
  int m_base_lo, m_base_hi, m_cnt, m_max, m_ovf, m_ready, m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_mask();
    int m = 0;
    if (m_max < 0) return 0;
    while (m < m_max) m = m * 2 + 1;
    return m;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_vlo[i] = 1'b0;
      m_vhi[i] = 1'b0;
    end
    m_base_lo = 0; m_base_hi = 0; m_cnt = 0; m_max = -1; m_ovf = 0; m_ready = 0;
  endtask

  task automatic m_packet(input int num, input int laddr, input int size, input int raddr);
    int page = (raddr >> 13) % 4096;
    if (m_cnt < 2 * DEPTH - 1) m_cnt++;
    if (num >= DEPTH) begin
      m_ovf = 1;
      return;
    end
    if (num > m_max) m_max = num;
    if (laddr <= 'h8000) begin
      m_lo[num] = page; m_vlo[num] = 1'b1;
      if (num == 0) m_base_lo = page;
      if (size > 'h2000) begin
        m_hi[num] = (page + 1) % 4096; m_vhi[num] = 1'b1;
        if (num == 0) m_base_hi = (page + 1) % 4096;
      end
    end else begin
      m_hi[num] = page; m_vhi[num] = 1'b1;
      if (num == 0) m_base_hi = page;
    end
  endtask

  task automatic m_expect(input int bank, input int hi, output int page, output int vld);
    int eff = bank & m_mask();
    if (hi != 0) begin
      vld  = m_vhi[eff] ? 1 : 0;
      page = m_vhi[eff] ? m_hi[eff] : m_base_hi;
    end else begin
      vld  = m_vlo[eff] ? 1 : 0;
      page = m_vlo[eff] ? m_lo[eff] : m_base_lo;
    end
  endtask

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic send_packet(input int num, input int laddr, input int size, input int raddr);
    cart_bank_wr    = 1'b1;
    cart_bank_num   = 16'(num);
    cart_bank_laddr = 16'(laddr);
    cart_bank_size  = 16'(size);
    cart_bank_raddr = 25'(raddr);
    tick();
    cart_bank_wr = 1'b0;
    m_packet(num, laddr, size, raddr);
  endtask

  task automatic load_start();
    cart_loading = 1'b1;
    tick();
    m_clear();
  endtask

  task automatic load_end();
    cart_loading = 1'b0;
    tick();
    m_ready = (m_cnt != 0) ? 1 : 0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_cnt"},   32'(bank_cnt),     32'(m_cnt));
    check({tag, "_mask"},  32'(bank_mask),    32'(m_mask()));
    check({tag, "_ready"}, 32'(table_ready),  32'(m_ready));
    check({tag, "_ovf"},   32'(err_overflow), 32'(m_ovf));
  endtask

  task automatic lookup(input int c, input int bank, input int hi, input string tag);
    int pe, ve, lat;
    m_expect(bank, hi, pe, ve);
    lk_bank[c*BANK_W +: BANK_W] = BANK_W'(bank);
    lk_hi[c]  = (hi != 0);
    lk_req[c] = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!lk_ack[c] && lat < 10);
    lk_req[c] = 1'b0;
    m_last = c;
    check({tag, "_lat"},  32'(lat), 32'd2);
    check({tag, "_page"}, 32'(lk_page[c*PAGE_W +: PAGE_W]), 32'(pe));
    check({tag, "_vld"},  32'(lk_valid[c]), 32'(ve));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int np, num, laddr, size, nxt, gr_prev, gr_now, e_pg[NCH], e_vd[NCH];

  initial begin
    reset = 1'b0; cart_loading = 1'b0; cart_bank_wr = 1'b0;
    cart_bank_num = '0; cart_bank_laddr = '0; cart_bank_size = '0; cart_bank_raddr = '0;
    lk_req = '0; lk_bank = '0; lk_hi = '0;
    m_clear();
    m_last = NCH - 1;
    tick(); tick();
    check_status("reset");
    check("reset_ack",   32'(lk_ack),   32'd0);
    check("reset_page",  32'(lk_page),  32'd0);
    check("reset_valid", 32'(lk_valid), 32'd0);
    reset = 1'b1;
    tick();

    // 16K packet at bank 3: both halves from consecutive pages.
    load_start();
    send_packet(3, 'h8000, 'h4000, 'h0A000);
    load_end();
    check_status("p16k");
    lookup(0, 3, 0, "p16k_lo");
    lookup(1, 3, 1, "p16k_hi");
    tick(); tick();
    check("p16k_hold_page", 32'(lk_page[0 +: PAGE_W]), 32'h005);
    check("p16k_hold_vld",  32'(lk_valid[0]), 32'd1);

    // Banks 0..3 ROML only, then an out-of-range bank number.
    load_start();
    for (int b = 0; b < 4; b++) send_packet(b, 'h8000, 'h2000, (('h100 + b) << 13));
    send_packet(300, 'h8000, 'h2000, 'h1FFE000);
    load_end();
    check_status("mirror");
    lookup(0, 6, 0, "mirror_lo");
    lookup(1, 6, 1, "mirror_hi");
    lookup(0, 44, 0, "ovf_tbl");
    load_start();
    check_status("reload");
    load_end();
    check_status("empty_load");
    lookup(1, 1, 0, "empty_lk");

    // Load rising edge together with a packet: the packet survives the clear.
    cart_loading = 1'b1;
    m_clear();
    send_packet(0, 'hA000, 'h2000, 'h1234567 & 'h1FFFFFF);
    check_status("coinc");
    lookup(1, 9, 1, "coinc_hi");
    lookup(0, 0, 0, "coinc_lo");
    load_end();

    // Counter saturation.
    load_start();
    for (int p = 0; p < 2 * DEPTH + 3; p++) send_packet(1000, 'h8000, 'h2000, 0);
    load_end();
    check_status("sat");

    // Randomized loads and lookups.
    for (int l = 0; l < 3; l++) begin
      load_start();
      np = $urandom_range(4, 16);
      for (int p = 0; p < np; p++) begin
        num = ($urandom_range(0, 9) == 0) ? $urandom_range(256, 299)
                                          : $urandom_range(0, (l == 0) ? 15 : 255);
        case ($urandom_range(0, 3))
          0:       laddr = 'h8000;
          1:       laddr = 'hA000;
          2:       laddr = 'hE000;
          default: laddr = $urandom_range(0, 'hFFFF);
        endcase
        case ($urandom_range(0, 2))
          0:       size = 'h2000;
          1:       size = 'h4000;
          default: size = $urandom_range(0, 'hFFFF);
        endcase
        send_packet(num, laddr, size, $urandom_range(0, 'h1FFFFFF));
      end
      load_end();
      check_status("rnd_load");
      for (int k = 0; k < 16; k++)
        lookup($urandom_range(0, NCH - 1), $urandom_range(0, DEPTH - 1),
               $urandom_range(0, 1), "rnd_lk");
    end

    // Both channels streaming; a packet write stalls one grant.
    load_start();
    for (int b = 0; b < 4; b++) begin
      send_packet(b, 'h8000, 'h2000, (('h200 + b) << 13));
      send_packet(b, 'hA000, 'h2000, (('h300 + b) << 13));
    end
    load_end();
    m_expect(2, 0, e_pg[0], e_vd[0]);
    m_expect(3, 1, e_pg[1], e_vd[1]);
    lk_bank = {8'd3, 8'd2};
    lk_hi   = 2'b10;
    lk_req  = 2'b11;
    nxt     = (m_last + 1) % NCH;
    gr_prev = -1;
    for (int t = 0; t < 12; t++) begin
      if (t == 5) begin
        cart_bank_wr = 1'b1; cart_bank_num = 16'd1; cart_bank_laddr = 16'h8000;
        cart_bank_size = 16'h2000; cart_bank_raddr = 25'h0ABC000;
        gr_now = -1;
      end else begin
        gr_now = nxt;
        nxt    = (nxt + 1) % NCH;
        m_last = gr_now;
      end
      tick();
      if (t == 5) begin
        cart_bank_wr = 1'b0;
        m_packet(1, 'h8000, 'h2000, 'h0ABC000);
      end
      check("stream_ack", 32'(lk_ack), (gr_prev < 0) ? 32'd0 : (32'd1 << gr_prev));
      if (gr_prev >= 0) begin
        check("stream_page", 32'(lk_page[gr_prev*PAGE_W +: PAGE_W]), 32'(e_pg[gr_prev]));
        check("stream_vld",  32'(lk_valid[gr_prev]), 32'(e_vd[gr_prev]));
      end
      gr_prev = gr_now;
    end
    lk_req[1 - gr_prev] = 1'b0;
    tick();
    check("drain_ack", 32'(lk_ack), 32'd1 << gr_prev);
    lk_req = '0;
    tick();
    check("drain_idle", 32'(lk_ack), 32'd0);
    check_status("stream_wr");
    lookup(0, 1, 0, "stream_new");

    // Reset with lookups in flight.
    lk_bank = {8'd3, 8'd2};
    lk_hi   = 2'b00;
    lk_req  = 2'b11;
    tick(); tick();
    reset = 1'b0;
    #1;
    m_clear();
    m_last = NCH - 1;
    check_status("rst_mid");
    check("rst_mid_ack",   32'(lk_ack),   32'd0);
    check("rst_mid_page",  32'(lk_page),  32'd0);
    check("rst_mid_valid", 32'(lk_valid), 32'd0);
    tick();
    check("rst_hold_ack", 32'(lk_ack), 32'd0);
    lk_req = '0;
    tick();
    reset = 1'b1;
    tick();
    check("rst_rel_ack", 32'(lk_ack), 32'd0);
    check_status("rst_rel");
    lookup(0, 2, 0, "rst_fb");
    load_start();
    send_packet(2, 'h8000, 'h2000, 'h40000);
    load_end();
    check_status("rst_reload");
    lookup(1, 2, 0, "rst_reload_lk");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cart_bank_table.md
# cart_bank_table

Parametrised bank-mapping table for the C64 cartridge subsystem. It records, while a CRT file streams in, which SDRAM 8K page holds the ROML and ROMH half of every chip-packet bank. It then serves bank→page lookups to several mapper channels through an arbitrated, pipelined request/ack port. It sits between the CRT loader and the cartridge mapper logic. Over the fixed 64-entry lo/hi arrays it adds larger depth, bank mirroring, valid tracking and multi-channel access.

## Interface
- BANK_W, 8, bank-number bits; table depth 2^BANK_W
- PAGE_W, 12, SDRAM page bits, taken from cart_bank_raddr[PAGE_W+12:13]
- NCH, 2, number of lookup channels (1..8)

Ports:
- clk32  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cart_loading  in  1  CRT load in progress
- cart_bank_wr  in  1  one-cycle strobe, chip packet header valid
- cart_bank_num  in  16  chip packet bank number
- cart_bank_laddr  in  16  chip packet load address
- cart_bank_size  in  16  chip packet length
- cart_bank_raddr  in  25  SDRAM address of packet data
- bank_cnt  out  BANK_W+1  packets accepted this load (saturating)
- bank_mask  out  BANK_W  mirror mask covering the highest bank loaded
- table_ready  out  1  load finished with ≥1 packet
- err_overflow  out  1  sticky: packet bank number ≥ 2^BANK_W
- lk_req  in  NCH  per-channel lookup request (level)
- lk_bank  in  NCH*BANK_W  requested bank, channel c at [c*BANK_W +: BANK_W]
- lk_hi  in  NCH  1 = ROMH half, 0 = ROML half
- lk_ack  out  NCH  one-cycle completion pulse
- lk_page  out  NCH*PAGE_W  result page, held until that channel's next ack
- lk_valid  out  NCH  result came from a loaded entry

## Operation
- Storage: two RAMs (lo, hi) of 2^BANK_W × PAGE_W, each with one write port and one read port. Per-entry valid bits are held in flops. Registers base_lo and base_hi hold the bank-0 pages.
- Load start (rising edge of cart_loading): all valid bits, bank_cnt, bank_mask, err_overflow, table_ready and base registers clear in one cycle.
- Packet write (cart_bank_wr, with page = raddr[PAGE_W+12:13]):
  - If bank_num ≥ 2^BANK_W: set err_overflow, increment bank_cnt, no table write.
  - Else if laddr ≤ 0x8000: write lo[bank] = page and set its valid bit. If size > 0x2000, also write hi[bank] = page+1 (mod 2^PAGE_W) and set its valid bit.
  - Else: write hi[bank] = page and set its valid bit.
  - Bank 0 writes also update the matching base register(s).
  - bank_mask becomes the smear of max(written bank numbers): all bits at and below the highest set bit.
- Load end (falling edge of cart_loading): table_ready = (bank_cnt ≠ 0).
- Lookup:
  - Effective bank = lk_bank & bank_mask.
  - If the selected half's entry is valid: lk_page = RAM data, lk_valid = 1.
  - Otherwise: lk_page = base_lo or base_hi, lk_valid = 0.
  - Lookups are served whether or not table_ready is set.
- Arbitration:
  - Round-robin over the requesting channels that have no lookup in flight. At most one grant per cycle.
  - A packet write in a cycle blocks any grant in that cycle.

## Timing
- Reset values: bank_cnt = 0, bank_mask = 0, table_ready = 0, err_overflow = 0, lk_ack = 0, lk_page = 0, lk_valid = 0, all valid bits = 0. RAM contents are undefined.
- A grant is issued at edge N, the RAM is read at edge N+1, and lk_ack[c] is high for cycle N+2 with lk_page and lk_valid valid. Latency is 2 cycles; throughput is 1 lookup per cycle across channels.
- A channel keeps lk_req, lk_bank and lk_hi stable until its ack. It is masked from arbitration from grant until ack. Holding lk_req through the ack cycle issues a new request on the next arbitration.
- bank_mask and the valid bits update at the write edge, so a lookup granted the cycle after a write sees the new entry.
- A loading rising edge coincident with cart_bank_wr: the clear happens first and that packet's write is kept.
- A write and a lookup in flight to the same entry: the read returns the old data; no bypass.
- Reset mid-lookup: in-flight lookups are dropped and no ack is issued.
- Rising edge of cart_loading: in-flight lookups still complete, returning fallback results.
- bank_cnt saturates at 2^(BANK_W+1)−1.

## Structure
- Package cart_pkg holds: ROML_LADDR = 16'h8000, BANK8K_SIZE = 16'h2000, and the default BANK_W, PAGE_W and NCH values, shared with the mapper.
- Sub-module cart_rr_arb(N): round-robin arbiter taking request and mask vectors and producing a one-hot grant. It is stall-capable, driven by the write-block input.

## Test plan
- Load a 16K packet (bank 3, laddr 0x8000, size 0x4000, raddr 0x0A000) → lookup of bank 3 lo returns page 0x005 and hi returns page 0x006, both with lk_valid = 1; bank_mask = 0x03.
- Load banks 0..3 of 8K ROML only, then look up bank 6 lo → resolves to bank 2's page, lk_valid = 1. Look up bank 6 hi → returns base_hi (0), lk_valid = 0.
- Packet with bank_num 300 at BANK_W = 8 → err_overflow = 1, bank_cnt increments, table unchanged. A new loading edge clears err_overflow.
- NCH = 2 with both channels holding lk_req continuously → acks alternate ch0, ch1, ch0…, one ack per cycle after a 2-cycle fill.
- cart_bank_wr asserted during a steady request stream → no grant in the write cycle; the ack gap appears 2 cycles later.
- Assert reset with two lookups in flight → no acks, all outputs zero, table_ready = 0 until the next load completes.
